// File: rtl/nonce_sampler.sv
// Schnorr nonce sampler: captures a PRNG sample, reduces it mod q with a bit-serial
// restoring remainder, rejects k = 0 and hands accepted k out over valid/ready.
module nonce_sampler #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             prng_start,
  output logic [WIDTH-1:0] k_out,
  output logic             k_valid,
  input  logic             k_ready,
  output logic             busy,
  output logic             q_err,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [IDX_W-1:0] idx;

  logic [WIDTH:0]   t_val;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   r_next;

  assign prng_start = (state == ST_WAIT);
  assign busy       = (state == ST_REDUCE) || (state == ST_OUT);

  // One restoring step: shift in the next sample bit, subtract Q when it fits.
  // R stays below Q, so the shifted value always fits in WIDTH+1 bits.
  always_comb begin
    t_val  = (r_reg << 1) | {{WIDTH{1'b0}}, s_reg[idx]};
    q_ext  = {1'b0, q_reg};
    r_next = (t_val >= q_ext) ? (t_val - q_ext) : t_val;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_WAIT;
      s_reg      <= '0;
      q_reg      <= '0;
      r_reg      <= '0;
      idx        <= '0;
      k_out      <= '0;
      k_valid    <= 1'b0;
      q_err      <= 1'b0;
      drop_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      if (rnd_valid && (state != ST_WAIT) && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);

      case (state)
        ST_WAIT: begin
          if (rnd_valid) begin
            s_reg <= rnd_in;
            q_reg <= q;
            r_reg <= '0;
            idx   <= IDX_W'(WIDTH - 1);
            // A modulus below 2 leaves no valid nonce; flag it and keep waiting.
            if (q < WIDTH'(2))
              q_err <= 1'b1;
            else
              state <= ST_REDUCE;
          end
        end

        ST_REDUCE: begin
          r_reg <= r_next;
          idx   <= idx - IDX_W'(1);
          if (idx == '0) begin
            if (r_next != '0) begin
              k_out   <= r_next[WIDTH-1:0];
              k_valid <= 1'b1;
              state   <= ST_OUT;
            end else begin
              if (reject_cnt != {CNT_W{1'b1}})
                reject_cnt <= reject_cnt + CNT_W'(1);
              state <= ST_WAIT;
            end
          end
        end

        ST_OUT: begin
          if (k_ready) begin
            k_valid <= 1'b0;
            state   <= ST_WAIT;
          end
        end

        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sampler.sv
// Directed bench for nonce_sampler: reduction results, latency, rejects,
// q_err, backpressure, drop/reject counters and mid-reduction reset.
module tb_nonce_sampler;

  localparam int WIDTH = 256;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rnd_in;
  logic             rnd_valid;
  logic             prng_start;
  logic [WIDTH-1:0] k_out;
  logic             k_valid;
  logic             k_ready;
  logic             busy;
  logic             q_err;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] reject_cnt;

  int total;
  int bad;

  nonce_sampler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .q          (q),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .prng_start (prng_start),
    .k_out      (k_out),
    .k_valid    (k_valid),
    .k_ready    (k_ready),
    .busy       (busy),
    .q_err      (q_err),
    .drop_cnt   (drop_cnt),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge, away from posedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] rin, input logic [WIDTH-1:0] qv);
    rnd_in    = rin;
    q         = qv;
    rnd_valid = 1'b1;
    @(negedge clk);
    rnd_valid = 1'b0;
  endtask

  // Steps WIDTH+2 cycles after capture; reports the first cycle k_valid was seen
  // (-1 if never) and whether busy dropped during the reduction cycles.
  task automatic run_reduce(output int kv_at, output bit busy_bad);
    kv_at    = -1;
    busy_bad = 1'b0;
    for (int i = 1; i <= WIDTH + 2; i++) begin
      @(negedge clk);
      if (i < WIDTH && !busy) busy_bad = 1'b1;
      if (k_valid && kv_at < 0) kv_at = i;
    end
  endtask

  int kv_at;
  bit busy_bad;
  bit stable_bad;
  logic [WIDTH-1:0] all_ones;
  logic [WIDTH-1:0] k_hold;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    q         = '0;
    rnd_in    = '0;
    rnd_valid = 1'b0;
    k_ready   = 1'b0;
    all_ones  = '1;

    // Reset state
    do_reset();
    check("rst_prng_start", {256'd0, prng_start}, 257'd1);
    check("rst_k_valid", {256'd0, k_valid}, 257'd0);
    check("rst_k_out", {1'b0, k_out}, 257'd0);
    check("rst_busy", {256'd0, busy}, 257'd0);
    check("rst_cnts", {241'd0, drop_cnt, reject_cnt}, 257'd0);

    // 100 mod 7 = 2, latency and handshake
    pulse(256'd100, 256'd7);
    check("t1_prng_after", {256'd0, prng_start}, 257'd0);
    run_reduce(kv_at, busy_bad);
    check("t1_latency", 257'(kv_at), 257'(WIDTH));
    check("t1_busy", {256'd0, busy_bad}, 257'd0);
    check("t1_k_out", {1'b0, k_out}, 257'd2);
    k_ready = 1'b1;
    @(negedge clk);
    k_ready = 1'b0;
    check("t1_prng_back", {256'd0, prng_start}, 257'd1);
    check("t1_kv_clr", {256'd0, k_valid}, 257'd0);
    check("t1_k_keep", {1'b0, k_out}, 257'd2);

    // 14 mod 7 = 0 rejected, then 15 mod 7 = 1
    do_reset();
    pulse(256'd14, 256'd7);
    run_reduce(kv_at, busy_bad);
    check("t2_no_kv", 257'(kv_at), {257{1'b1}});
    check("t2_reject", {249'd0, reject_cnt}, 257'd1);
    check("t2_prng", {256'd0, prng_start}, 257'd1);
    pulse(256'd15, 256'd7);
    run_reduce(kv_at, busy_bad);
    check("t2_k_out", {1'b0, k_out}, 257'd1);
    check("t2_kv", {256'd0, k_valid}, 257'd1);

    // q = 2^256-1: all-ones rejected, 2^256-2 passes through unreduced
    do_reset();
    pulse(all_ones, all_ones);
    run_reduce(kv_at, busy_bad);
    check("t3_reject", {249'd0, reject_cnt}, 257'd1);
    check("t3_no_kv", 257'(kv_at), {257{1'b1}});
    pulse(all_ones - 256'd1, all_ones);
    run_reduce(kv_at, busy_bad);
    check("t3_k_out", {1'b0, k_out}, {1'b0, all_ones - 256'd1});
    check("t3_latency", 257'(kv_at), 257'(WIDTH));

    // q = 1 sets q_err and stays in WAIT
    do_reset();
    pulse(256'd100, 256'd1);
    check("t4_q_err", {256'd0, q_err}, 257'd1);
    check("t4_prng", {256'd0, prng_start}, 257'd1);
    check("t4_busy", {256'd0, busy}, 257'd0);
    @(negedge clk);
    check("t4_kv", {256'd0, k_valid}, 257'd0);
    check("t4_cnts", {241'd0, drop_cnt, reject_cnt}, 257'd0);
    check("t4_sticky", {256'd0, q_err}, 257'd1);

    // Backpressure with drops
    do_reset();
    pulse(256'd100, 256'd7);
    run_reduce(kv_at, busy_bad);
    k_hold     = k_out;
    stable_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rnd_valid = (i == 3 || i == 8 || i == 15);
      rnd_in    = 256'd5;
      @(negedge clk);
      rnd_valid = 1'b0;
      if (!k_valid || k_out !== k_hold) stable_bad = 1'b1;
    end
    check("t5_stable", {256'd0, stable_bad}, 257'd0);
    check("t5_k_out", {1'b0, k_out}, 257'd2);
    check("t5_drops", {249'd0, drop_cnt}, 257'd3);
    k_ready = 1'b1;
    @(negedge clk);
    k_ready = 1'b0;
    check("t5_accept", {256'd0, k_valid}, 257'd0);

    // Reject counter saturation
    do_reset();
    for (int i = 1; i <= 258; i++) begin
      pulse(256'd14, 256'd7);
      run_reduce(kv_at, busy_bad);
      if (i == 254) check("t6_cnt254", {249'd0, reject_cnt}, 257'd254);
    end
    check("t6_saturate", {249'd0, reject_cnt}, 257'd255);
    check("t6_drops", {249'd0, drop_cnt}, 257'd0);

    // Reset mid-reduction at step 100, then a clean reduction
    pulse(256'd100, 256'd7);
    for (int i = 0; i < 100; i++) @(negedge clk);
    check("t7_busy_pre", {256'd0, busy}, 257'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t7_prng", {256'd0, prng_start}, 257'd1);
    check("t7_kv", {256'd0, k_valid}, 257'd0);
    check("t7_cnts", {241'd0, drop_cnt, reject_cnt}, 257'd0);
    check("t7_k_out", {1'b0, k_out}, 257'd0);
    pulse(256'd100, 256'd7);
    run_reduce(kv_at, busy_bad);
    check("t7_again", {1'b0, k_out}, 257'd2);
    check("t7_latency", 257'(kv_at), 257'(WIDTH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
